prime_sieve_engine: RTL and testbench

- Parametrised next-generation prime generator. Runs a Sieve of Eratosthenes up to a user bound, compacts the primes into a list RAM, and serves indexed lookups.
- Replaces the fixed 10-bit sieve, populate and controller trio with one self-contained block. It has no square-root ROM: the outer loop ends on an i*i > max_n compare.
- Adds prime-count reporting, list-overflow detection, abort/restart and a registered query handshake.

---
 rtl/prime_sieve_engine.sv | 210 +++++++++++++++++++++
 tb/tb_prime_sieve_engine.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/prime_sieve_engine.sv
// Sieve of Eratosthenes prime generator with a compacted prime list
// and a registered indexed-lookup port.
module prime_sieve_engine #(
    parameter  int N_WIDTH    = 10,
    parameter  int LIST_DEPTH = 256,
    localparam int LIST_AW    = $clog2(LIST_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_WIDTH-1:0] max_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [LIST_AW:0]   prime_count,
    output logic               overflow,
    input  logic               query_valid,
    input  logic [LIST_AW-1:0] query_index,
    output logic               query_ready,
    output logic               query_rvalid,
    output logic               query_hit,
    output logic [N_WIDTH-1:0] query_prime
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_OUTER,
        S_INNER,
        S_POPULATE,
        S_DONE
    } state_t;

    localparam logic [LIST_AW:0]   DEPTH_C = (LIST_AW + 1)'(LIST_DEPTH);
    localparam logic [N_WIDTH-1:0] TWO_C   = N_WIDTH'(2);

    state_t               state, state_n;
    logic [N_WIDTH-1:0]   max_n_r, max_n_r_n;
    logic [N_WIDTH-1:0]   k, k_n;
    logic [N_WIDTH-1:0]   i, i_n;
    logic [N_WIDTH:0]     j, j_n;
    logic [LIST_AW:0]     idx, idx_n;
    logic                 busy_n, done_n, overflow_n;
    logic [LIST_AW:0]     prime_count_n;

    logic                 bm_we;
    logic [N_WIDTH-1:0]   bm_addr;
    logic                 bm_wd;
    logic                 list_we;

    logic                 composite [2**N_WIDTH];
    logic [N_WIDTH-1:0]   list_mem  [LIST_DEPTH];

    logic [2*N_WIDTH-1:0] sq;
    logic [N_WIDTH+1:0]   j_sum;
    logic                 start_acc;
    logic                 q_acc;
    logic                 q_hit_c;

    assign sq        = i * i;
    assign j_sum     = {1'b0, j} + {2'b00, i};
    assign start_acc = start && !(state == S_DONE && max_n == max_n_r);
    assign query_ready = done;
    assign q_acc     = query_valid && done;
    assign q_hit_c   = {1'b0, query_index} < prime_count;

    // State and datapath registers, all taking their next values from below
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            max_n_r     <= '0;
            k           <= '0;
            i           <= '0;
            j           <= '0;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            prime_count <= '0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            max_n_r     <= max_n_r_n;
            k           <= k_n;
            i           <= i_n;
            j           <= j_n;
            idx         <= idx_n;
            busy        <= busy_n;
            done        <= done_n;
            prime_count <= prime_count_n;
            overflow    <= overflow_n;
        end
    end

    // Next-state logic; an accepted start overrides whatever the state does
    always_comb begin
        state_n       = state;
        max_n_r_n     = max_n_r;
        k_n           = k;
        i_n           = i;
        j_n           = j;
        idx_n         = idx;
        busy_n        = busy;
        done_n        = done;
        prime_count_n = prime_count;
        overflow_n    = overflow;
        bm_we         = 1'b0;
        bm_addr       = k;
        bm_wd         = 1'b0;
        list_we       = 1'b0;
        if (start_acc) begin
            max_n_r_n     = max_n;
            done_n        = 1'b0;
            prime_count_n = '0;
            overflow_n    = 1'b0;
            busy_n        = 1'b1;
            k_n           = '0;
            state_n       = S_CLEAR;
        end else begin
            unique case (state)
                S_CLEAR: begin
                    bm_we   = 1'b1;
                    bm_addr = k;
                    bm_wd   = 1'b0;
                    if (k == max_n_r) begin
                        i_n     = TWO_C;
                        state_n = S_OUTER;
                    end else begin
                        k_n = k + N_WIDTH'(1);
                    end
                end
                S_OUTER: begin
                    if (sq > {{N_WIDTH{1'b0}}, max_n_r}) begin
                        if (max_n_r < TWO_C) begin
                            prime_count_n = '0;
                            busy_n        = 1'b0;
                            done_n        = 1'b1;
                            state_n       = S_DONE;
                        end else begin
                            k_n     = TWO_C;
                            idx_n   = '0;
                            state_n = S_POPULATE;
                        end
                    end else if (composite[i]) begin
                        i_n = i + N_WIDTH'(1);
                    end else begin
                        j_n     = sq[N_WIDTH:0];
                        state_n = S_INNER;
                    end
                end
                S_INNER: begin
                    bm_we   = 1'b1;
                    bm_addr = j[N_WIDTH-1:0];
                    bm_wd   = 1'b1;
                    if (j_sum > {2'b00, max_n_r}) begin
                        i_n     = i + N_WIDTH'(1);
                        state_n = S_OUTER;
                    end else begin
                        j_n = j_sum[N_WIDTH:0];
                    end
                end
                S_POPULATE: begin
                    if (!composite[k]) begin
                        if (idx < DEPTH_C) begin
                            list_we = 1'b1;
                            idx_n   = idx + (LIST_AW + 1)'(1);
                        end else begin
                            overflow_n = 1'b1;
                        end
                    end
                    if (k == max_n_r) begin
                        prime_count_n = idx_n;
                        busy_n        = 1'b0;
                        done_n        = 1'b1;
                        state_n       = S_DONE;
                    end else begin
                        k_n = k + N_WIDTH'(1);
                    end
                end
                S_IDLE, S_DONE: begin
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Bitmap and prime list storage, synchronous writes
    always_ff @(posedge clk) begin
        if (bm_we) begin
            composite[bm_addr] <= bm_wd;
        end
        if (list_we) begin
            list_mem[idx[LIST_AW-1:0]] <= k;
        end
    end

    // Registered query response, one cycle after an accepted lookup
    always_ff @(posedge clk) begin
        if (reset) begin
            query_rvalid <= 1'b0;
            query_hit    <= 1'b0;
            query_prime  <= '0;
        end else begin
            query_rvalid <= q_acc;
            if (q_acc) begin
                query_hit   <= q_hit_c;
                query_prime <= q_hit_c ? list_mem[query_index] : '0;
            end
        end
    end

endmodule

// File: tb/tb_prime_sieve_engine.sv
// Randomized self-checking bench for prime_sieve_engine; two instances
// (256-entry and 16-entry lists) checked against a trial-division model.
module tb_prime_sieve_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start   [2];
    logic [9:0] max_n   [2];
    logic       qv      [2];
    logic [7:0] qi      [2];
    logic       busy    [2];
    logic       done    [2];
    logic       ovf     [2];
    logic       qr      [2];
    logic       rv      [2];
    logic       hit     [2];
    logic [9:0] qp      [2];
    logic [8:0] pc0;
    logic [4:0] pc1;

    int checks   = 0;
    int failures = 0;
    int dep   [2] = '{256, 16};
    int cur_n [2] = '{0, 0};
    int prm [$];

    always #5 clk = ~clk;

    prime_sieve_engine #(.N_WIDTH(10), .LIST_DEPTH(256)) dut0 (
        .clk(clk), .reset(reset), .max_n(max_n[0]), .start(start[0]),
        .busy(busy[0]), .done(done[0]), .prime_count(pc0),
        .overflow(ovf[0]), .query_valid(qv[0]), .query_index(qi[0]),
        .query_ready(qr[0]), .query_rvalid(rv[0]), .query_hit(hit[0]),
        .query_prime(qp[0])
    );

    prime_sieve_engine #(.N_WIDTH(10), .LIST_DEPTH(16)) dut1 (
        .clk(clk), .reset(reset), .max_n(max_n[1]), .start(start[1]),
        .busy(busy[1]), .done(done[1]), .prime_count(pc1),
        .overflow(ovf[1]), .query_valid(qv[1]), .query_index(qi[1][3:0]),
        .query_ready(qr[1]), .query_rvalid(rv[1]), .query_hit(hit[1]),
        .query_prime(qp[1])
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pcount(int d);
        return (d == 0) ? {23'd0, pc0} : {27'd0, pc1};
    endfunction

    function automatic void build(int n);
        prm.delete();
        for (int v = 2; v <= n; v++) begin
            bit p = 1'b1;
            for (int f = 2; f * f <= v; f++)
                if (v % f == 0) p = 1'b0;
            if (p) prm.push_back(v);
        end
    endfunction

    function automatic int exp_count(int d, int n);
        build(n);
        return (prm.size() < dep[d]) ? prm.size() : dep[d];
    endfunction

    task automatic kick(int d, int n);
        @(negedge clk);
        start[d] = 1'b1;
        max_n[d] = n[9:0];
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    task automatic wait_done(int d, string tag);
        int c = 0;
        while (!done[d] && c < 20000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done"}, {31'd0, done[d]}, 32'd1);
        chk({tag, "_busy_off"}, {31'd0, busy[d]}, 32'd0);
    endtask

    task automatic run(int d, int n, string tag);
        kick(d, n);
        cur_n[d] = n;
        wait_done(d, tag);
        build(n);
        chk({tag, "_count"}, pcount(d), exp_count(d, n));
        chk({tag, "_ovf"}, {31'd0, ovf[d]},
            (prm.size() > dep[d]) ? 32'd1 : 32'd0);
    endtask

    task automatic query(int d, int idx, string tag);
        int cnt;
        bit eh;
        cnt = exp_count(d, cur_n[d]);
        eh  = idx < cnt;
        @(negedge clk);
        qv[d] = 1'b1;
        qi[d] = idx[7:0];
        @(negedge clk);
        qv[d] = 1'b0;
        chk({tag, "_rvalid"}, {31'd0, rv[d]}, 32'd1);
        chk({tag, "_hit"}, {31'd0, hit[d]}, {31'd0, eh});
        chk({tag, "_prime"}, {22'd0, qp[d]}, eh ? prm[idx] : 0);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            max_n[d] = '0;
            qv[d]    = 1'b0;
            qi[d]    = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_done", {31'd0, done[0]}, 32'd0);
        chk("rst_count", pcount(0), 32'd0);
        chk("rst_ovf", {31'd0, ovf[0]}, 32'd0);
        chk("rst_ready", {31'd0, qr[0]}, 32'd0);
        chk("rst_rvalid", {31'd0, rv[0]}, 32'd0);
        chk("rst_prime", {22'd0, qp[0]}, 32'd0);

        run(0, 100, "n100");
        chk("n100_lit", pcount(0), 32'd25);
        query(0, 11, "n100_q11");
        chk("q11_lit", {22'd0, qp[0]}, 32'd37);

        kick(0, 500);
        cur_n[0] = 500;
        chk("n500_busy_rise", {31'd0, busy[0]}, 32'd1);
        chk("n500_done_low", {31'd0, done[0]}, 32'd0);
        wait_done(0, "n500");
        chk("n500_count", pcount(0), exp_count(0, 500));
        query(0, 57, "n500_q57");
        query(0, 95, "n500_q95");

        kick(0, 500);
        chk("cached_busy", {31'd0, busy[0]}, 32'd0);
        chk("cached_done", {31'd0, done[0]}, 32'd1);
        chk("cached_count", pcount(0), exp_count(0, 500));
        query(0, 57, "cached_q57");

        run(0, 1023, "n1023");
        query(0, 171, "n1023_q171");

        kick(0, 500);
        repeat (510) @(negedge clk);
        chk("abort_busy", {31'd0, busy[0]}, 32'd1);
        run(0, 30, "abort30");
        query(0, 9, "abort30_q9");

        run(1, 100, "d16_n100");
        query(1, 15, "d16_q15");
        run(1, 1, "d16_n1");
        run(1, 2, "d16_n2");
        query(1, 0, "d16_q0");

        kick(0, 1023);
        cur_n[0] = 1023;
        @(negedge clk);
        qv[0] = 1'b1;
        qi[0] = 8'd3;
        @(negedge clk);
        qv[0] = 1'b0;
        chk("busy_query_drop", {31'd0, rv[0]}, 32'd0);
        repeat (3000) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy[0]}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
        chk("midrst_done", {31'd0, done[0]}, 32'd0);
        chk("midrst_count", pcount(0), 32'd0);
        chk("midrst_rvalid", {31'd0, rv[0]}, 32'd0);
        run(0, 100, "post_rst");

        for (int r = 0; r < 6; r++) begin
            run(0, int'($urandom_range(0, 1023)), "rnd0");
            for (int q = 0; q < 4; q++)
                query(0, int'($urandom_range(0, 255)), "rnd0_q");
            run(1, int'($urandom_range(0, 200)), "rnd1");
            for (int q = 0; q < 3; q++)
                query(1, int'($urandom_range(0, 15)), "rnd1_q");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
